// File: rtl/grover_controller.sv
// Grover search controller over an 8-entry signed amplitude register file.
// Sequence: INIT -> (ORACLE -> SUM -> DIFFUSE) x num_iter -> ARGMAX -> DONE.
module grover_controller #(
   parameter logic signed [7:0] INIT_AMP = 8'sd32,
   parameter int unsigned       NUM_BIT  = 3
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [NUM_BIT-1:0]        target,
   input  logic [1:0]                num_iter,
   input  logic [NUM_BIT-1:0]        rd_addr,
   output logic signed [7:0]         rd_data,
   output logic                      busy,
   output logic                      done,
   output logic [NUM_BIT-1:0]        result
);

   localparam int unsigned AMP_W    = 8;
   localparam int unsigned SUM_W    = 12;
   localparam int unsigned MEAN_W   = 10;
   localparam int unsigned DIFF_W   = 11;
   localparam int unsigned ITER_W   = 2;
   localparam int unsigned NUM_SAMP = 1 << NUM_BIT;

   localparam logic signed [AMP_W-1:0]  AMP_MAX = AMP_W'(127);
   localparam logic signed [AMP_W-1:0]  AMP_MIN = AMP_W'(128);
   localparam logic signed [DIFF_W-1:0] SAT_HI  = DIFF_W'(127);
   localparam logic signed [DIFF_W-1:0] SAT_LO  = -DIFF_W'(128);
   localparam logic [NUM_BIT-1:0]       K_LAST  = NUM_BIT'(NUM_SAMP - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_INIT    = 3'd1,
      S_ORACLE  = 3'd2,
      S_SUM     = 3'd3,
      S_DIFFUSE = 3'd4,
      S_ARGMAX  = 3'd5,
      S_DONE    = 3'd6
   } state_t;

   state_t                    r_state;
   state_t                    w_state_next;

   logic signed [AMP_W-1:0]   r_amp [NUM_SAMP];
   logic signed [SUM_W-1:0]   r_sum;
   logic signed [MEAN_W-1:0]  r_two_mean;
   logic [ITER_W-1:0]         r_iter_cnt;
   logic [NUM_BIT-1:0]        r_k;
   logic [NUM_BIT-1:0]        r_target;
   logic [ITER_W-1:0]         r_num_iter;
   logic [NUM_BIT-1:0]        r_best_idx;
   logic signed [AMP_W-1:0]   r_best_val;
   logic [NUM_BIT-1:0]        r_result;
   logic                      r_busy;
   logic                      r_done;

   logic                      w_last_k;
   logic                      w_more_iter;
   logic signed [AMP_W-1:0]   w_amp_k;
   logic signed [AMP_W-1:0]   w_amp_tgt;
   logic signed [AMP_W-1:0]   w_oracle_val;
   logic signed [SUM_W-1:0]   w_sum_base;
   logic signed [SUM_W-1:0]   w_sum_next;
   logic signed [DIFF_W-1:0]  w_diff;
   logic                      w_take;

   // Clamp a wide signed value into the 8-bit amplitude range
   function automatic logic signed [AMP_W-1:0] sat8(input logic signed [DIFF_W-1:0] x);
      logic signed [AMP_W-1:0] y;
      if (x > SAT_HI) begin
         y = AMP_MAX;
      end else if (x < SAT_LO) begin
         y = AMP_MIN;
      end else begin
         y = x[AMP_W-1:0];
      end
      return y;
   endfunction

   // Shared datapath terms: current sample, oracle negation, running sum, diffusion, argmax
   always_comb begin
      w_last_k     = (r_k == K_LAST);
      w_more_iter  = ((3'({1'b0, r_iter_cnt}) + 3'd1) < 3'({1'b0, r_num_iter}));
      w_amp_k      = r_amp[r_k];
      w_amp_tgt    = r_amp[r_target];
      w_oracle_val = (w_amp_tgt == AMP_MIN) ? AMP_MAX : -w_amp_tgt;
      w_sum_base   = (r_k == '0) ? '0 : r_sum;
      w_sum_next   = w_sum_base + $signed({{(SUM_W-AMP_W){w_amp_k[AMP_W-1]}}, w_amp_k});
      w_diff       = $signed({{(DIFF_W-MEAN_W){r_two_mean[MEAN_W-1]}}, r_two_mean})
                   - $signed({{(DIFF_W-AMP_W){w_amp_k[AMP_W-1]}}, w_amp_k});
      w_take       = (r_k == '0) || (w_amp_k > r_best_val);
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:    if (start) w_state_next = S_INIT;
         S_INIT:    w_state_next = (r_num_iter != '0) ? S_ORACLE : S_ARGMAX;
         S_ORACLE:  w_state_next = S_SUM;
         S_SUM:     if (w_last_k) w_state_next = S_DIFFUSE;
         S_DIFFUSE: if (w_last_k) w_state_next = w_more_iter ? S_ORACLE : S_ARGMAX;
         S_ARGMAX:  if (w_last_k) w_state_next = S_DONE;
         S_DONE:    w_state_next = S_IDLE;
         default:   w_state_next = S_IDLE;
      endcase
   end

   // Search parameters captured on an accepted start; frozen while busy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_target   <= '0;
         r_num_iter <= '0;
      end else if ((r_state == S_IDLE) && start) begin
         r_target   <= target;
         r_num_iter <= num_iter;
      end
   end

   // Sample index walks 0..7 through SUM, DIFFUSE and ARGMAX, parked at 0 elsewhere
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_k <= '0;
      end else if ((r_state == S_SUM) || (r_state == S_DIFFUSE) || (r_state == S_ARGMAX)) begin
         r_k <= r_k + NUM_BIT'(1);
      end else begin
         r_k <= '0;
      end
   end

   // Iteration counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_iter_cnt <= '0;
      end else if (r_state == S_INIT) begin
         r_iter_cnt <= '0;
      end else if ((r_state == S_DIFFUSE) && w_last_k) begin
         r_iter_cnt <= r_iter_cnt + ITER_W'(1);
      end
   end

   // Amplitude sum and its doubled mean, frozen at the last SUM step
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum      <= '0;
         r_two_mean <= '0;
      end else if (r_state == S_SUM) begin
         r_sum <= w_sum_next;
         if (w_last_k) begin
            r_two_mean <= w_sum_next[SUM_W-1:SUM_W-MEAN_W];
         end
      end
   end

   // Amplitude register file: written only by INIT, ORACLE and DIFFUSE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SAMP; i++) begin
            r_amp[i] <= '0;
         end
      end else begin
         case (r_state)
            S_INIT: begin
               for (int i = 0; i < NUM_SAMP; i++) begin
                  r_amp[i] <= INIT_AMP;
               end
            end
            S_ORACLE:  r_amp[r_target] <= w_oracle_val;
            S_DIFFUSE: r_amp[r_k]      <= sat8(w_diff);
            default:   ;
         endcase
      end
   end

   // Running maximum; strict compare keeps the lowest index on ties
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_best_idx <= '0;
         r_best_val <= '0;
      end else if ((r_state == S_ARGMAX) && w_take) begin
         r_best_idx <= r_k;
         r_best_val <= w_amp_k;
      end
   end

   // Result captured on the edge that enters DONE, held until the next search ends
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result <= '0;
      end else if ((r_state == S_ARGMAX) && w_last_k) begin
         r_result <= w_take ? r_k : r_best_idx;
      end
   end

   // Status flags registered from the next state so they align with the state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_busy <= (w_state_next != S_IDLE);
         r_done <= (w_state_next == S_DONE);
      end
   end

   assign rd_data = r_amp[rd_addr];
   assign busy    = r_busy;
   assign done    = r_done;
   assign result  = r_result;

endmodule
